// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses UART write/read frames, drives one register-bus cycle per frame
// and returns a single reply byte through uart_tx.
module uart_cmd_ctrl #(
  parameter int unsigned AW          = 8,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  output logic          bus_we,
  output logic          bus_re,
  input  logic [7:0]    bus_rdata,
  input  logic          bus_ack,
  output logic          error
);

  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [7:0] OpWrite  = 8'h57;
  localparam logic [7:0] OpRead   = 8'h52;
  localparam logic [7:0] RspAck   = 8'h4B;
  localparam logic [7:0] RspBadOp = 8'h3F;
  localparam logic [7:0] RspBusTo = 8'hEE;

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StBusWr, StBusRd, StSend, StSendWait
  } state_e;

  state_e          state_q;
  logic            is_write_q;
  logic [TW-1:0]   idle_cnt_q;
  logic [AckW-1:0] ack_cnt_q;
  logic            skip_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      idle_cnt_q <= '0;
      ack_cnt_q  <= '0;
      skip_q     <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_we     <= 1'b0;
      bus_re     <= 1'b0;
      error      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      error    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_ready) begin
            if (rx_data == OpWrite || rx_data == OpRead) begin
              is_write_q <= (rx_data == OpWrite);
              idle_cnt_q <= '0;
              state_q    <= StGetAddr;
            end else begin
              tx_data <= RspBadOp;
              error   <= 1'b1;
              state_q <= StSend;
            end
          end
        end
        StGetAddr: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (rx_ready) begin
            bus_addr   <= rx_data[AW-1:0];
            idle_cnt_q <= '0;
            ack_cnt_q  <= '0;
            if (is_write_q) begin
              state_q <= StGetData;
            end else begin
              bus_re  <= 1'b1;
              state_q <= StBusRd;
            end
          end else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
            error      <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= StIdle;
          end else begin
            idle_cnt_q <= idle_cnt_q + TW'(1);
          end
        end
        StGetData: begin
          if (rx_ready) begin
            bus_wdata  <= rx_data;
            bus_we     <= 1'b1;
            idle_cnt_q <= '0;
            ack_cnt_q  <= '0;
            state_q    <= StBusWr;
          end else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
            error      <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= StIdle;
          end else begin
            idle_cnt_q <= idle_cnt_q + TW'(1);
          end
        end
        StBusWr, StBusRd: begin
          if (rx_ready) error <= 1'b1;
          // Ack is checked first so it wins over a coincident timeout.
          if (bus_ack) begin
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            tx_data   <= (state_q == StBusWr) ? RspAck : bus_rdata;
            ack_cnt_q <= '0;
            state_q   <= StSend;
          end else if (ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            error     <= 1'b1;
            tx_data   <= RspBusTo;
            ack_cnt_q <= '0;
            state_q   <= StSend;
          end else begin
            ack_cnt_q <= ack_cnt_q + AckW'(1);
          end
        end
        StSend: begin
          if (rx_ready) error <= 1'b1;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            skip_q   <= 1'b1;
            state_q  <= StSendWait;
          end
        end
        StSendWait: begin
          if (rx_ready) error <= 1'b1;
          // tx_busy may lag tx_start by a cycle, so the first cycle is ignored.
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomised scoreboard bench for uart_cmd_ctrl with modelled uart_tx and register bus.
module tb_uart_cmd_ctrl;

  localparam int unsigned AW          = 6;
  localparam int unsigned TIMEOUT     = 40;
  localparam int unsigned ACK_TIMEOUT = 16;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          rx_ready  = 1'b0;
  logic [7:0]    rx_data   = 8'h00;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy   = 1'b0;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic          bus_we;
  logic          bus_re;
  logic [7:0]    bus_rdata = 8'h00;
  logic          bus_ack   = 1'b0;
  logic          error;

  uart_cmd_ctrl #(
    .AW          (AW),
    .TIMEOUT     (TIMEOUT),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .error     (error)
  );

  initial forever #5 clk = ~clk;

  typedef struct { bit we; int addr; int wdata; int len; } bus_exp_t;
  typedef struct { int delay; bit noack; logic [7:0] rdata; } plan_t;

  int       exp_tx[$];
  bus_exp_t exp_bus[$];
  plan_t    plan_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int err_seen  = 0;
  bit rst_flag  = 1'b0;
  bit tx_pend   = 1'b0;
  int busy_left = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // uart_tx model plus reply monitor
  initial begin : tx_side
    bit prev_start;
    int dur_q;
    prev_start = 1'b0;
    dur_q = 0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        chk(!prev_start, "tx_start_single_cycle", int'(prev_start), 0);
        chk(!tx_busy, "tx_start_while_busy", int'(tx_busy), 0);
        if (exp_tx.size() == 0) begin
          chk(1'b0, "tx_start_without_pending_reply", int'(tx_data), 0);
        end else begin
          int e;
          e = exp_tx.pop_front();
          chk(int'(tx_data) == e, "tx_data", int'(tx_data), e);
        end
        if ($urandom_range(0, 1) == 0) begin
          tx_busy   = 1'b1;
          busy_left = $urandom_range(2, 8);
        end else begin
          tx_pend = 1'b1;
          dur_q   = $urandom_range(2, 8);
        end
      end else if (tx_pend) begin
        tx_pend   = 1'b0;
        tx_busy   = 1'b1;
        busy_left = dur_q;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      prev_start = tx_start;
    end
  end

  initial forever begin
    @(negedge clk);
    if (error) err_seen++;
  end

  // Register-bus responder: acks after the planned number of request cycles.
  initial begin : bus_resp
    bit    active;
    int    cnt;
    plan_t cur;
    active = 1'b0;
    cnt = 0;
    cur = '{delay: 0, noack: 1'b1, rdata: 8'h00};
    forever begin
      @(negedge clk);
      bus_rdata = 8'($urandom);
      if (bus_we || bus_re) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else cur = '{delay: 0, noack: 1'b1, rdata: 8'h00};
        end
        cnt++;
        if (!cur.noack && cnt == cur.delay + 1) begin
          bus_ack   = 1'b1;
          bus_rdata = cur.rdata;
        end else begin
          bus_ack = 1'b0;
        end
      end else begin
        active  = 1'b0;
        bus_ack = 1'b0;
      end
    end
  end

  initial begin : bus_mon
    bit       active;
    int       len;
    bus_exp_t cur;
    active = 1'b0;
    len = 0;
    cur = '{we: 1'b0, addr: 0, wdata: 0, len: 0};
    forever begin
      @(negedge clk);
      if (bus_we && bus_re) chk(1'b0, "bus_we_and_bus_re", 3, 1);
      if (bus_we || bus_re) begin
        if (!active) begin
          active = 1'b1;
          len = 0;
          if (exp_bus.size() == 0) begin
            chk(1'b0, "bus_request_unexpected", int'({bus_we, bus_re}), 0);
            cur = '{we: bus_we, addr: 0, wdata: 0, len: -1};
          end else begin
            cur = exp_bus.pop_front();
            chk(bus_we == cur.we, "bus_cycle_kind_we", int'(bus_we), int'(cur.we));
            chk(int'(bus_addr) == cur.addr, "bus_addr", int'(bus_addr), cur.addr);
            if (cur.we) chk(int'(bus_wdata) == cur.wdata, "bus_wdata", int'(bus_wdata), cur.wdata);
          end
        end
        len++;
      end else if (active) begin
        active = 1'b0;
        if (!rst_flag && cur.len >= 0) chk(len == cur.len, "bus_request_cycles", len, cur.len);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return TIMEOUT - 1;
    if (r < 4) return 0;
    return $urandom_range(1, 8);
  endfunction

  task automatic flush_and_reset();
    exp_tx.delete();
    exp_bus.delete();
    plan_q.delete();
    rst_flag = 1'b1;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rst_flag = 1'b0;
  endtask

  task automatic settle();
    int quiet;
    bit done;
    quiet = 0;
    done  = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_bus.size() == 0 && !tx_busy && !tx_pend && !bus_we && !bus_re)
        quiet++;
      else
        quiet = 0;
      if (quiet >= 3) done = 1'b1;
    end
    if (!done) begin
      chk(1'b0, "frame_settle_timeout", exp_tx.size() + exp_bus.size(), 0);
      flush_and_reset();
    end
  endtask

  // kind: 0 write, 1 read, 2 bad opcode (op), 3 timeout after opcode, 4 timeout after address.
  // delay < 0 means the bus never acknowledges.
  task automatic run_frame(input int kind, input logic [7:0] op, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] rd, input int delay,
                           input bit overrun);
    int       base;
    int       exp_err;
    bit       noack;
    bit       seen;
    plan_t    p;
    bus_exp_t e;
    base    = err_seen;
    exp_err = 0;
    noack   = (delay < 0);
    case (kind)
      0, 1: begin
        p = '{delay: delay, noack: noack, rdata: rd};
        e = '{we: (kind == 0), addr: int'(addr) % (1 << AW), wdata: int'(data),
              len: noack ? int'(ACK_TIMEOUT) : delay + 1};
        plan_q.push_back(p);
        exp_bus.push_back(e);
        exp_tx.push_back(noack ? 'hEE : (kind == 0 ? 'h4B : int'(rd)));
        if (noack) exp_err++;
        send_byte((kind == 0) ? 8'h57 : 8'h52, rand_gap());
        if (kind == 0) begin
          send_byte(addr, rand_gap());
          send_byte(data, 0);
        end else begin
          send_byte(addr, 0);
        end
      end
      2: begin
        exp_tx.push_back('h3F);
        exp_err++;
        send_byte(op, 0);
      end
      3: begin
        exp_err++;
        send_byte(($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52, TIMEOUT);
      end
      default: begin
        exp_err++;
        send_byte(8'h57, rand_gap());
        send_byte(addr, TIMEOUT);
      end
    endcase
    if (overrun && kind < 3) begin
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (tx_start) seen = 1'b1;
      end
      chk(seen, "overrun_reply_started", int'(seen), 1);
      if (seen) begin
        exp_err++;
        send_byte(8'($urandom), 0);
      end
    end
    settle();
    chk(err_seen - base == exp_err, "error_pulse_count", err_seen - base, exp_err);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int strobes;
    bit seen;
    logic [7:0] op;

    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk({tx_start, bus_we, bus_re, error} == 4'b0, "reset_strobes",
        int'({tx_start, bus_we, bus_re, error}), 0);
    chk(tx_data == 8'h00, "reset_tx_data", int'(tx_data), 0);
    chk(bus_addr == '0, "reset_bus_addr", int'(bus_addr), 0);
    chk(bus_wdata == 8'h00, "reset_bus_wdata", int'(bus_wdata), 0);

    reset   = 1'b0;
    base    = err_seen;
    strobes = 0;
    repeat (20) begin
      @(negedge clk);
      strobes += int'(tx_start) + int'(bus_we) + int'(bus_re) + int'(error);
    end
    chk(strobes == 0, "idle_no_strobes", strobes, 0);

    run_frame(0, 8'h00, 8'h12, 8'hA5, 8'h00, 3, 1'b0);
    chk(bus_addr == 6'h12, "write_bus_addr_held", int'(bus_addr), 'h12);
    chk(bus_wdata == 8'hA5, "write_bus_wdata_held", int'(bus_wdata), 'hA5);
    run_frame(1, 8'h00, 8'h34, 8'h00, 8'hC3, 1, 1'b0);
    run_frame(2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    run_frame(0, 8'h00, 8'h05, 8'h66, 8'h00, 2, 1'b1);
    run_frame(1, 8'h00, 8'hFF, 8'h00, 8'h9A, 0, 1'b0);
    run_frame(3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    run_frame(1, 8'h00, 8'h21, 8'h00, 8'h00, -1, 1'b0);
    run_frame(1, 8'h00, 8'h07, 8'h00, 8'h5D, ACK_TIMEOUT - 1, 1'b0);

    // Reset during the bus write: request must drop at once and no reply follows.
    base = err_seen;
    plan_q.push_back('{delay: 0, noack: 1'b1, rdata: 8'h00});
    exp_bus.push_back('{we: 1'b1, addr: 'h2A, wdata: 'h77, len: -1});
    send_byte(8'h57, 0);
    send_byte(8'h2A, 0);
    send_byte(8'h77, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_we) seen = 1'b1;
    end
    chk(seen, "reset_test_bus_we_rose", int'(seen), 1);
    @(negedge clk);
    rst_flag = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    chk(bus_we == 1'b0, "reset_drops_bus_we", int'(bus_we), 0);
    chk({tx_start, error} == 2'b0, "reset_no_strobes", int'({tx_start, error}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rst_flag = 1'b0;
    settle();
    chk(err_seen == base, "reset_no_error", err_seen - base, 0);
    run_frame(1, 8'h00, 8'h3C, 8'h00, 8'h81, 2, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int r;
      int kind;
      int delay;
      r = $urandom_range(0, 99);
      if (r < 35) kind = 0;
      else if (r < 70) kind = 1;
      else if (r < 78) kind = 2;
      else if (r < 84) kind = 3;
      else if (r < 90) kind = 4;
      else kind = $urandom_range(0, 1);
      if (r >= 90) delay = -1;
      else if ($urandom_range(0, 5) == 0) delay = ACK_TIMEOUT - 1;
      else delay = $urandom_range(0, 6);
      do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
      run_frame(kind, op, 8'($urandom), 8'($urandom), 8'($urandom), delay,
                ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Byte-level command sequencer between uart_rx/uart_tx and an 8-bit internal register bus. Parses framed commands from the receive byte stream, issues single register reads and writes, and sequences the one-byte reply to the transmitter. It is the only bus master on the debug register bus and the only client of uart_tx.

Parameters:
AW, 8, register address width in bits; the address byte is truncated to AW when AW < 8.
TIMEOUT, 4096, clk cycles allowed between bytes inside a frame before the frame is aborted.
ACK_TIMEOUT, 255, clk cycles allowed for bus_ack before a bus cycle is aborted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_ready  in  1  one-cycle strobe from uart_rx; rx_data is valid on this cycle
rx_data  in  8  received byte
tx_start  out  1  one-cycle strobe; uart_tx loads tx_data
tx_data  out  8  byte to transmit
tx_busy  in  1  uart_tx busy; rises no later than 1 cycle after tx_start
bus_addr  out  AW  register address
bus_wdata  out  8  write data
bus_we  out  1  write request, held until ack or abort
bus_re  out  1  read request, held until ack or abort
bus_rdata  in  8  read data, valid when bus_ack=1
bus_ack  in  1  bus completion strobe
error  out  1  one-cycle pulse on any protocol or bus fault

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset: state=IDLE. tx_start, bus_we, bus_re and error are 0. tx_data, bus_addr, bus_wdata and both counters are 0. Reset mid-frame or mid-bus-cycle drops everything on the next clk edge and sends no reply.
- Frame formats:
  - Write: 0x57, addr, data -> reply 0x4B.
  - Read: 0x52, addr -> reply is the read byte.
  - Any other opcode -> reply 0x3F plus an error pulse, then IDLE.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, SEND, SEND_WAIT.
- IDLE: on rx_ready, decode rx_data.
  - 0x57 or 0x52 -> GET_ADDR, opcode latched.
  - Else -> SEND with tx_data=0x3F, error=1.
- GET_ADDR: on rx_ready, latch bus_addr = rx_data[AW-1:0].
  - Write -> GET_DATA.
  - Read -> BUS_RD; bus_re=1 from the next cycle.
- GET_DATA: on rx_ready, latch bus_wdata -> BUS_WR; bus_we=1 from the next cycle.
- Inter-byte timeout: in GET_ADDR/GET_DATA an idle counter resets on each rx_ready. When it reaches TIMEOUT: error=1, return to IDLE, no reply.
- BUS_WR / BUS_RD:
  - Request held high until bus_ack is sampled 1 and deasserted the cycle after ack.
  - On ack: tx_data = 0x4B (write) or bus_rdata (read), go to SEND.
  - If ACK_TIMEOUT cycles pass without ack: drop the request, error=1, tx_data=0xEE, go to SEND.
- SEND: wait for tx_busy=0, then assert tx_start for exactly one cycle -> SEND_WAIT.
- SEND_WAIT: skip the first cycle (the transmitter latency), then wait for tx_busy=0 -> IDLE.
- Overrun: rx_ready in BUS_WR, BUS_RD, SEND or SEND_WAIT discards the byte and pulses error. The state does not change.
- Simultaneous events:
  - rx_ready on the same cycle the inter-byte timeout expires: the byte wins and the counter clears.
  - bus_ack on the same cycle ACK_TIMEOUT expires: ack wins.
- Latency: the bus request asserts 1 cycle after the final frame byte's rx_ready. tx_start fires 2 cycles after bus_ack when tx_busy=0.
- At most one tx_start per frame. tx_start is never asserted while tx_busy=1.

Test Plan:
- Reset check: hold reset 4 cycles; all outputs 0. Release reset with rx_ready=0 for 20 cycles -> state stays IDLE, no strobes.
- Write: bytes 0x57, 0x12, 0xA5, bus acks after 3 cycles -> bus_addr=0x12, bus_wdata=0xA5, bus_we high exactly 4 cycles, one tx_start with tx_data=0x4B.
- Read: bytes 0x52, 0x34, bus_rdata=0xC3 with ack after 1 cycle -> bus_re high 2 cycles, tx_data=0xC3, one tx_start.
- Bad opcode and overrun:
  - Byte 0x00 -> tx_data=0x3F and one error pulse.
  - A byte injected while in SEND_WAIT -> an error pulse, and the next valid frame still completes correctly.
- Timeouts:
  - Byte 0x57 followed by silence for TIMEOUT cycles -> an error pulse, no tx_start, IDLE.
  - Read with bus_ack never asserted -> bus_re drops after ACK_TIMEOUT, tx_data=0xEE.
- Reset mid-frame: assert reset during BUS_WR -> bus_we=0 on the next clk edge, no reply. A subsequent read frame completes normally.
